instr_encoder: RTL and testbench

- Program-side counterpart of the opcode control decoder.
- Accepts instruction fields over a valid/ready handshake and assembles 32-bit MIPS words (R/I/J formats).
- Rejects any opcode the control decoder does not support.
- Writes legal words sequentially into instruction memory for the monocycle core to fetch and decode.
- Sits between the testbench/loader and the instruction memory write port.

---
 rtl/isa_pkg.sv | 33 +++
 rtl/instr_pack.sv | 41 ++++
 rtl/instr_encoder.sv | 128 ++++++++++++
 tb/tb_instr_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA constants shared by the instruction encoder and the control decoder:
// instruction formats, supported opcodes and the encoder state encoding.
package isa_pkg;

   typedef enum logic [1:0] {
      FMT_R    = 2'd0,
      FMT_I    = 2'd1,
      FMT_J    = 2'd2,
      FMT_RSVD = 2'd3
   } fmt_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FULL
   } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of instruction fields into a 32-bit MIPS word, plus
// a flag saying whether the opcode is one the control decoder supports.
module instr_pack
   import isa_pkg::*;
(
   input  logic [1:0]  fmt,
   input  logic [5:0]  opcode,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      word  = 32'h0;
      legal = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: begin
            word  = {OP_RTYPE, rs, rt, rd, shamt, funct};
            legal = (opcode == OP_RTYPE);
         end
         FMT_I: begin
            word  = {opcode, rs, rt, imm};
            legal = opcode inside {OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
                                   OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW};
         end
         FMT_J: begin
            word  = {opcode, target};
            legal = opcode inside {OP_J, OP_JAL};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Accepts instruction field bundles over valid/ready, encodes legal ones and
// writes them sequentially into instruction memory; illegal bundles are dropped.
module instr_encoder
   import isa_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              illegal,
   output logic              full
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                illegal_q, illegal_d;
   logic                we_q, we_d;
   logic [31:0]         wdata_q, wdata_d;

   logic [31:0]         pack_word;
   logic                pack_legal;
   logic                accept;
   logic [ADDR_W:0]     words_before;
   logic                last_word;

   instr_pack u_pack (
      .fmt    (fmt),
      .opcode (opcode),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .shamt  (shamt),
      .funct  (funct),
      .imm    (imm),
      .target (target),
      .word   (pack_word),
      .legal  (pack_legal)
   );

   always_comb begin
      accept       = in_valid & (state_q == S_RUN);
      // Words already accepted, counting a write still in flight this cycle.
      words_before = start ? '0 : count_q + {{ADDR_W{1'b0}}, we_q};
      last_word    = accept & pack_legal & ((words_before + CNT_ONE) == DEPTH_C);

      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      illegal_d = illegal_q | (accept & ~pack_legal);
      we_d      = accept & pack_legal;
      wdata_d   = we_d ? pack_word : wdata_q;

      if (we_q) begin
         count_d = count_q + CNT_ONE;
         if (count_q != DEPTH_C - CNT_ONE) addr_d = addr_q + ADR_ONE;
      end

      case (state_q)
         S_RUN: begin
            if (stop)           state_d = S_IDLE;
            else if (last_word) state_d = S_FULL;
         end
         S_FULL: if (stop) state_d = S_IDLE;
         default: ;
      endcase

      // An in-flight write still lands at the old address; start only rewinds afterwards.
      if (start) begin
         state_d   = last_word ? S_FULL : S_RUN;
         addr_d    = BASE_C;
         count_d   = '0;
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         illegal_q <= illegal_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
      end
   end

   assign in_ready   = (state_q == S_RUN);
   assign full       = (state_q == S_FULL);
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign word_count = count_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a behavioural model queues expected
// memory writes and a monitor checks every write the encoder issues.
module tb_instr_encoder;

   localparam int ADDR_W    = 4;
   localparam int DEPTH     = 4;
   localparam int BASE_ADDR = 0;

   logic              clock;
   logic              reset, start, stop, in_valid;
   logic              in_ready;
   logic [1:0]        fmt;
   logic [5:0]        opcode, funct;
   logic [4:0]        rs, rt, rd, shamt;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   word_count;
   logic              illegal, full;

   instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .imm(imm), .target(target),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .word_count(word_count), .illegal(illegal), .full(full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  opcode;
      logic [4:0]  rs, rt, rd, shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
   } bundle_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_checks = 0;
   int  n_errors = 0;

   // Behavioural model state
   bit  m_run, m_full, m_illegal;
   int  m_accepted;

   logic [5:0] i_ops [11] = '{6'h04, 6'h05, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

   function automatic bit ref_legal(logic [1:0] f, logic [5:0] op);
      case (f)
         2'd0: return op == 6'h00;
         2'd1: begin
            foreach (i_ops[k]) if (i_ops[k] == op) return 1'b1;
            return 1'b0;
         end
         2'd2: return (op == 6'h02) || (op == 6'h03);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(bundle_t b);
      case (b.fmt)
         2'd0: return {6'b0, b.rs, b.rt, b.rd, b.shamt, b.funct};
         2'd1: return {b.opcode, b.rs, b.rt, b.imm};
         2'd2: return {b.opcode, b.target};
         default: return 32'h0;
      endcase
   endfunction

   function automatic bundle_t mk(logic [1:0] f, logic [5:0] op, logic [4:0] s, logic [4:0] t,
                                  logic [4:0] d, logic [4:0] sh, logic [5:0] fn,
                                  logic [15:0] im, logic [25:0] tg);
      bundle_t b;
      b.fmt = f; b.opcode = op; b.rs = s; b.rt = t; b.rd = d; b.shamt = sh;
      b.funct = fn; b.imm = im; b.target = tg;
      return b;
   endfunction

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b = mk(2'($urandom_range(0, 3)), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
      if ($urandom_range(0, 3) != 0) begin
         case (b.fmt)
            2'd0: b.opcode = 6'h00;
            2'd1: b.opcode = i_ops[$urandom_range(0, 10)];
            2'd2: b.opcode = 6'($urandom_range(2, 3));
            default: ;
         endcase
      end
      return b;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic drive(bundle_t b);
      fmt = b.fmt; opcode = b.opcode; rs = b.rs; rt = b.rt; rd = b.rd;
      shamt = b.shamt; funct = b.funct; imm = b.imm; target = b.target;
   endtask

   task automatic offer(bundle_t b);
      drive(b);
      in_valid = 1'b1;
      @(negedge clock);
      check("in_ready", 32'(in_ready), 32'(m_run));
      if (m_run) begin
         if (ref_legal(b.fmt, b.opcode)) begin
            exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + m_accepted), data: ref_word(b)});
            m_accepted++;
            if (m_accepted == DEPTH) begin
               m_run  = 1'b0;
               m_full = 1'b1;
            end
         end else begin
            m_illegal = 1'b1;
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic idle(int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      m_run = 1'b1; m_full = 1'b0; m_illegal = 1'b0; m_accepted = 0;
   endtask

   task automatic status_check();
      int exp_addr;
      exp_addr = BASE_ADDR + ((m_accepted == DEPTH) ? DEPTH - 1 : m_accepted);
      check("word_count", 32'(word_count), 32'(m_accepted));
      check("illegal", 32'(illegal), 32'(m_illegal));
      check("full", 32'(full), 32'(m_full));
      check("in_ready_idle", 32'(in_ready), 32'(m_run));
      check("imem_addr", 32'(imem_addr), 32'(exp_addr));
      check("pending_writes", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every write strobe must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clock);
         if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
               check("write_data", imem_wdata, mon_e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
      drive(mk(2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0));
      m_run = 1'b0; m_full = 1'b0; m_illegal = 1'b0; m_accepted = 0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'h0);
      status_check();
      reset = 1'b0;
      idle(1);

      // R-type encode and write
      pulse_start();
      offer(mk(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0));
      idle(2);
      check("r_word_const", imem_wdata, 32'h00221820);
      status_check();

      // Back-to-back I then J
      pulse_start();
      offer(mk(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0));
      offer(mk(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000));
      idle(2);
      check("jal_word_const", imem_wdata, 32'h0C100000);
      status_check();

      // Illegal drops; flag stays set across a later legal write
      pulse_start();
      offer(mk(2'd2, 6'h08, 5'd4, 5'd5, 5'd6, 5'd7, 6'h1, 16'h1234, 26'h3));
      offer(mk(2'd3, 6'h00, 5'd4, 5'd5, 5'd6, 5'd7, 6'h1, 16'h1234, 26'h3));
      idle(2);
      check("illegal_set", 32'(illegal), 32'd1);
      status_check();
      offer(mk(2'd1, 6'h23, 5'd9, 5'd10, 5'd0, 5'd0, 6'h0, 16'h0040, 26'h0));
      idle(2);
      status_check();

      // Fill to DEPTH with five continuous offers
      pulse_start();
      for (int i = 0; i < 5; i++)
         offer(mk(2'd1, 6'h0D, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'h0, 16'(16'hA000 + i), 26'h0));
      idle(2);
      check("full_flag", 32'(full), 32'd1);
      status_check();

      // Restart from FULL
      pulse_start();
      status_check();

      // Stop in the cycle after an accept: write still lands
      offer(mk(2'd0, 6'h00, 5'd7, 5'd8, 5'd9, 5'd2, 6'h02, 16'h0, 26'h0));
      stop = 1'b1;
      in_valid = 1'b0;
      @(posedge clock); #1;
      stop = 1'b0;
      m_run = 1'b0;
      idle(2);
      status_check();

      // Reset in the same cycle as an accept
      pulse_start();
      offer(mk(2'd1, 6'h0F, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'hBEEF, 26'h0));
      drive(mk(2'd1, 6'h2B, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0));
      in_valid = 1'b1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      m_run = 1'b0; m_full = 1'b0; m_illegal = 1'b0; m_accepted = 0;
      check("rst_mid_we", 32'(imem_we), 32'd0);
      check("rst_mid_wdata", imem_wdata, 32'h0);
      status_check();
      idle(2);

      // Randomized rounds
      for (int r = 0; r < 25; r++) begin
         pulse_start();
         for (int k = 0, n = $urandom_range(1, 7); k < n; k++) begin
            offer(rand_bundle());
            if ($urandom_range(0, 2) == 0) idle(1);
         end
         idle(2);
         status_check();
      end

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
